// File: rtl/sr_load_scheduler.sv
// sr_load_scheduler: shares the ASIC serial configuration port between a
// 16-bit dynamic-register loader and an 88-bit static-register loader.
// Pending requests are arbitrated in IDLE. The winner's word is captured into
// one shift register and sent MSB-first on MOSI. SCLK is divided from CLK,
// and SEL selects the target register.
//
// Build option: define SR_SCHED_STAT_PRIORITY_EN for fixed priority, where
// static wins when both requests are high. Without it, arbitration is
// round-robin on a last-served pointer.
//
// Handshake: each req is a level held by its requester until the matching
// ack. The ack is a one-cycle pulse in the first cycle of the frame. The
// requester's data must be stable while req is high. A req that drops before
// its ack is simply never granted.
module sr_load_scheduler #(
    parameter int SIZESRDYN  = 16,
    parameter int SIZESRSTAT = 88,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  dyn_req,
    input  logic [SIZESRDYN-1:0]  dyn_data,
    output logic                  dyn_ack,
    input  logic                  stat_req,
    input  logic [SIZESRSTAT-1:0] stat_data,
    output logic                  stat_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  SCLK,
    output logic                  SEL,
    output logic                  MOSI
);

    localparam int HALF_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SIZESRSTAT-1:0]  shreg_q, shreg_d;
    logic [6:0]             bit_cnt_q, bit_cnt_d;
    logic [HALF_W-1:0]      half_cnt_q, half_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   sel_q, sel_d;
    logic                   dyn_ack_q, dyn_ack_d;
    logic                   stat_ack_q, stat_ack_d;
    logic                   done_q, done_d;
    logic                   last_dyn_q, last_dyn_d;
    logic                   grant_dyn, grant_stat;

    // Pick the requester to serve if the scheduler is idle this cycle.
    always_comb begin
        grant_dyn  = 1'b0;
        grant_stat = 1'b0;
        if (dyn_req && stat_req) begin
`ifdef SR_SCHED_STAT_PRIORITY_EN
            grant_stat = 1'b1;
`else
            // Serve whichever side was not served last.
            if (last_dyn_q) grant_stat = 1'b1;
            else            grant_dyn  = 1'b1;
`endif
        end else if (dyn_req) begin
            grant_dyn = 1'b1;
        end else if (stat_req) begin
            grant_stat = 1'b1;
        end
    end

    // Next-state and datapath: capture on grant, shift on SCLK falls, quiet gap.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sclk_d     = sclk_q;
        sel_d      = sel_q;
        dyn_ack_d  = 1'b0;
        stat_ack_d = 1'b0;
        done_d     = 1'b0;
        last_dyn_d = last_dyn_q;

        case (state_q)
            IDLE: begin
                sel_d  = 1'b0;
                sclk_d = 1'b0;
                if (grant_dyn) begin
                    state_d    = SHIFT;
                    dyn_ack_d  = 1'b1;
                    shreg_d    = {dyn_data, {(SIZESRSTAT - SIZESRDYN){1'b0}}};
                    bit_cnt_d  = 7'(SIZESRDYN);
                    half_cnt_d = '0;
                    sel_d      = 1'b1;
                    last_dyn_d = 1'b1;
                end else if (grant_stat) begin
                    state_d    = SHIFT;
                    stat_ack_d = 1'b1;
                    shreg_d    = stat_data;
                    bit_cnt_d  = 7'(SIZESRSTAT);
                    half_cnt_d = '0;
                    sel_d      = 1'b0;
                    last_dyn_d = 1'b0;
                end
            end

            SHIFT: begin
                if (half_cnt_q == HALF_W'(CLK_DIV - 1)) begin
                    half_cnt_d = '0;
                    sclk_d     = ~sclk_q;
                    if (sclk_q) begin
                        // Falling edge: the bit on MOSI has been taken.
                        shreg_d   = shreg_q << 1;
                        bit_cnt_d = bit_cnt_q - 7'd1;
                        if (bit_cnt_q == 7'd1) begin
                            if (GAP_CYCLES == 0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                                sel_d   = 1'b0;
                            end else begin
                                state_d   = GAP;
                                gap_cnt_d = '0;
                            end
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    sel_d   = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                sclk_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            sel_q      <= 1'b0;
            dyn_ack_q  <= 1'b0;
            stat_ack_q <= 1'b0;
            done_q     <= 1'b0;
            last_dyn_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sclk_q     <= sclk_d;
            sel_q      <= sel_d;
            dyn_ack_q  <= dyn_ack_d;
            stat_ack_q <= stat_ack_d;
            done_q     <= done_d;
            last_dyn_q <= last_dyn_d;
        end
    end

    // The shift register drains to zero, so MOSI is low outside frames.
    assign MOSI     = shreg_q[SIZESRSTAT-1];
    assign SCLK     = sclk_q;
    assign SEL      = sel_q;
    assign dyn_ack  = dyn_ack_q;
    assign stat_ack = stat_ack_q;
    assign done     = done_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sr_load_scheduler.sv
// tb_sr_load_scheduler: directed and randomized frames for sr_load_scheduler.
// The reference model predicts the winner, the frame contents and the timing.
// Optional build macro followed: SR_SCHED_STAT_PRIORITY_EN.
module tb_sr_load_scheduler;

  localparam int DYN_N  = 16;
  localparam int STAT_N = 88;
  localparam int CD     = 4;
  localparam int GAPC   = 8;
  localparam int BUDGET = 4000;

  logic              CLK;
  logic              RST_N;
  logic              dyn_req;
  logic [DYN_N-1:0]  dyn_data;
  logic              dyn_ack;
  logic              stat_req;
  logic [STAT_N-1:0] stat_data;
  logic              stat_ack;
  logic              busy;
  logic              done;
  logic              SCLK;
  logic              SEL;
  logic              MOSI;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit model_last_dyn = 0;

  sr_load_scheduler #(
    .SIZESRDYN(DYN_N), .SIZESRSTAT(STAT_N), .CLK_DIV(CD), .GAP_CYCLES(GAPC)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .dyn_req(dyn_req), .dyn_data(dyn_data), .dyn_ack(dyn_ack),
    .stat_req(stat_req), .stat_data(stat_data), .stat_ack(stat_ack),
    .busy(busy), .done(done), .SCLK(SCLK), .SEL(SEL), .MOSI(MOSI)
  );

  // clock / cycle counter
  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end
  always @(posedge CLK) cyc++;

  // reference arbitration: 1 = dynamic, 2 = static, 0 = nothing to serve
  function automatic int model_pick(input bit d, input bit s);
    if (d && s) begin
`ifdef SR_SCHED_STAT_PRIORITY_EN
      return 2;
`else
      return model_last_dyn ? 2 : 1;
`endif
    end
    if (d) return 1;
    if (s) return 2;
    return 0;
  endfunction

  function automatic void model_served(input int k);
    model_last_dyn = (k == 1);
  endfunction

  task automatic do_reset();
    dyn_req = 0;
    stat_req = 0;
    RST_N = 0;
    repeat (3) @(negedge CLK);
    RST_N = 1;
    model_last_dyn = 0;
  endtask

  // driver/monitor: waits for an ack, then records one frame up to done
  task automatic capture_frame(input bit drop, output int kind, output int ack_c,
                               output int first_rise_c, output int done_c,
                               output logic [STAT_N-1:0] word, output int rises,
                               output logic mosi_first, output logic sel_ack,
                               output int sel_bad, output int busy_bad,
                               output int extra_acks, output logic done_busy,
                               output logic done_sel);
    int n;
    logic prev;
    kind = 0; ack_c = -1; first_rise_c = -1; done_c = -1; word = '0; rises = 0;
    mosi_first = 1'bx; sel_ack = 1'bx; sel_bad = 0; busy_bad = 0; extra_acks = 0;
    done_busy = 1'bx; done_sel = 1'bx;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(dyn_ack === 1'b1 || stat_ack === 1'b1) && n < BUDGET);
    if (n >= BUDGET) return;
    kind = (dyn_ack === 1'b1) ? 1 : 2;
    ack_c = cyc;
    sel_ack = SEL;
    mosi_first = MOSI;
    prev = SCLK;
    if (busy !== 1'b1) busy_bad++;
    if (drop) begin
      if (kind == 1) dyn_req = 0;
      else stat_req = 0;
    end
    n = 0;
    while (n < BUDGET) begin
      @(negedge CLK);
      n++;
      if (dyn_ack === 1'b1 || stat_ack === 1'b1) extra_acks++;
      if (done === 1'b1) begin
        done_c = cyc;
        done_busy = busy;
        done_sel = SEL;
        break;
      end
      if (busy !== 1'b1) busy_bad++;
      if (SEL !== sel_ack) sel_bad++;
      if (SCLK === 1'b1 && prev === 1'b0) begin
        if (rises == 0) first_rise_c = cyc;
        word = {word[STAT_N-2:0], MOSI};
        rises++;
      end
      prev = SCLK;
    end
  endtask

  int k, ac, frc, dc, rs, sb, bb, xa;
  logic [STAT_N-1:0] w;
  logic mf, sa, db, ds;

  task automatic test_reset();
    RST_N = 0;
    dyn_req = 0; stat_req = 0; dyn_data = '0; stat_data = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({dyn_ack, stat_ack, busy, done, SCLK, SEL, MOSI} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000", {dyn_ack, stat_ack, busy, done, SCLK, SEL, MOSI});
    end
    RST_N = 1;
    model_last_dyn = 0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({dyn_ack, stat_ack, busy, done, SCLK, SEL, MOSI} !== 7'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000000", {dyn_ack, stat_ack, busy, done, SCLK, SEL, MOSI});
    end
  endtask

  task automatic test_single_dyn();
    dyn_data = 16'hABC6;
    dyn_req = 1;
    capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
    model_served(1);
    checks++; if (k !== 1) begin errors++; $display("FAIL dyn_kind: got %0d expected 1", k); end
    checks++; if (sa !== 1'b1) begin errors++; $display("FAIL dyn_sel: got %b expected 1", sa); end
    checks++; if (mf !== 1'b1) begin errors++; $display("FAIL dyn_first_mosi: got %b expected 1", mf); end
    checks++; if (frc !== ac + CD) begin errors++; $display("FAIL dyn_first_rise: got %0d expected %0d", frc, ac + CD); end
    checks++; if (rs !== DYN_N) begin errors++; $display("FAIL dyn_rises: got %0d expected %0d", rs, DYN_N); end
    checks++; if (w !== {72'b0, 16'hABC6}) begin errors++; $display("FAIL dyn_word: got %h expected abc6", w); end
    checks++; if (dc !== ac + 136) begin errors++; $display("FAIL dyn_done_time: got %0d expected %0d", dc, ac + 136); end
    checks++; if (sb !== 0 || bb !== 0 || xa !== 0) begin errors++; $display("FAIL dyn_frame_stable: sel_bad %0d busy_bad %0d extra_acks %0d expected 0", sb, bb, xa); end
    checks++; if ({db, ds} !== 2'b00) begin errors++; $display("FAIL dyn_done_busy_sel: got %b expected 00", {db, ds}); end
  endtask

  task automatic test_single_stat();
    stat_data = 88'h123456789ABCDEF1234567;
    stat_req = 1;
    capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
    model_served(2);
    checks++; if (k !== 2) begin errors++; $display("FAIL stat_kind: got %0d expected 2", k); end
    checks++; if (sa !== 1'b0) begin errors++; $display("FAIL stat_sel: got %b expected 0", sa); end
    checks++; if (rs !== STAT_N) begin errors++; $display("FAIL stat_rises: got %0d expected %0d", rs, STAT_N); end
    checks++; if (w !== 88'h123456789ABCDEF1234567) begin errors++; $display("FAIL stat_word: got %h expected 123456789abcdef1234567", w); end
    checks++; if (dc !== ac + 2 * CD * STAT_N + GAPC) begin errors++; $display("FAIL stat_done_time: got %0d expected %0d", dc, ac + 2 * CD * STAT_N + GAPC); end
    checks++; if (sb !== 0 || bb !== 0 || xa !== 0) begin errors++; $display("FAIL stat_frame_stable: sel_bad %0d busy_bad %0d extra_acks %0d expected 0", sb, bb, xa); end
  endtask

  task automatic test_both_from_reset();
    int exp_k, prev_dc;
    do_reset();
    dyn_data = 16'h5A3C;
    stat_data = {32'hCAFEF00D, 32'h01234567, 24'h89ABCD};
    dyn_req = 1; stat_req = 1;
    exp_k = model_pick(1, 1);
    capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
    model_served(exp_k);
    checks++; if (k !== exp_k) begin errors++; $display("FAIL both_first_kind: got %0d expected %0d", k, exp_k); end
    prev_dc = dc;
    exp_k = (exp_k == 1) ? 2 : 1;
    capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
    model_served(exp_k);
    checks++; if (k !== exp_k) begin errors++; $display("FAIL both_second_kind: got %0d expected %0d", k, exp_k); end
    checks++; if (ac !== prev_dc + 1) begin errors++; $display("FAIL both_second_ack_time: got %0d expected %0d", ac, prev_dc + 1); end
    checks++; if (w !== ((exp_k == 1) ? {72'b0, dyn_data} : stat_data)) begin errors++; $display("FAIL both_second_word: got %h", w); end
  endtask

  task automatic test_no_starvation();
    int exp_k, prev_dc;
    dyn_data = 16'h1357;
    stat_data = {32'h2468ACE0, 32'hFFFF0000, 24'h00FF00};
    dyn_req = 1; stat_req = 1;
    prev_dc = -1;
    for (int f = 0; f < 4; f++) begin
      exp_k = model_pick(1, 1);
      capture_frame(0, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
      model_served(exp_k);
      checks++; if (k !== exp_k) begin errors++; $display("FAIL starve_kind_%0d: got %0d expected %0d", f, k, exp_k); end
      if (f > 0) begin
        checks++; if (ac !== prev_dc + 1) begin errors++; $display("FAIL starve_b2b_%0d: got %0d expected %0d", f, ac, prev_dc + 1); end
      end
      prev_dc = dc;
    end
    dyn_req = 0; stat_req = 0;
    @(negedge CLK);
  endtask

  task automatic test_reset_mid_frame();
    int n, r, acks;
    logic prev;
    stat_data = {32'h0F1E2D3C, 32'h4B5A6978, 24'h8796A5};
    stat_req = 1;
    n = 0;
    do begin @(negedge CLK); n++; end while (stat_ack !== 1'b1 && n < BUDGET);
    stat_req = 0;
    prev = SCLK; r = 0; n = 0;
    while (r < 40 && n < BUDGET) begin
      @(negedge CLK);
      n++;
      if (SCLK === 1'b1 && prev === 1'b0) r++;
      prev = SCLK;
    end
    checks++; if (r !== 40) begin errors++; $display("FAIL midreset_reach_bit40: got %0d expected 40", r); end
    #2 RST_N = 0;
    #1;
    checks++;
    if ({SCLK, SEL, MOSI, busy} !== 4'b0) begin
      errors++;
      $display("FAIL midreset_async_clear: got %b expected 0000", {SCLK, SEL, MOSI, busy});
    end
    repeat (2) @(negedge CLK);
    RST_N = 1;
    model_last_dyn = 0;
    acks = 0;
    repeat (20) begin
      @(negedge CLK);
      if (dyn_ack === 1'b1 || stat_ack === 1'b1 || busy === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL midreset_no_resume: got %0d activity cycles expected 0", acks); end
    stat_req = 1;
    capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
    model_served(2);
    checks++; if (k !== 2 || rs !== STAT_N) begin errors++; $display("FAIL midreset_refetch: kind %0d rises %0d expected 2 and %0d", k, rs, STAT_N); end
    checks++; if (w !== stat_data) begin errors++; $display("FAIL midreset_word: got %h expected %h", w, stat_data); end
  endtask

  task automatic test_short_pulse();
    int acks;
    dyn_data = 16'h8001;
    dyn_req = 1;
    fork
      capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
      begin
        repeat (30) @(negedge CLK);
        dyn_req = 1;
        @(negedge CLK);
        dyn_req = 0;
      end
    join
    model_served(1);
    checks++; if (k !== 1 || w !== {72'b0, 16'h8001}) begin errors++; $display("FAIL pulse_base_frame: kind %0d word %h expected 1 and 8001", k, w); end
    checks++; if (xa !== 0) begin errors++; $display("FAIL pulse_no_ack_in_frame: got %0d expected 0", xa); end
    acks = 0;
    repeat (40) begin
      @(negedge CLK);
      if (dyn_ack === 1'b1 || stat_ack === 1'b1 || busy === 1'b1) acks++;
    end
    checks++; if (acks !== 0) begin errors++; $display("FAIL pulse_no_extra_frame: got %0d activity cycles expected 0", acks); end
  endtask

  task automatic test_random_frames();
    int pat, exp_k, exp_n;
    logic [STAT_N-1:0] exp_w;
    for (int i = 0; i < 6; i++) begin
      pat = $urandom_range(1, 3);
      dyn_data = 16'($urandom());
      stat_data = {32'($urandom()), 32'($urandom()), 24'($urandom())};
      dyn_req = pat[0];
      stat_req = pat[1];
      exp_k = model_pick(pat[0], pat[1]);
      exp_w = (exp_k == 1) ? {72'b0, dyn_data} : stat_data;
      exp_n = (exp_k == 1) ? DYN_N : STAT_N;
      capture_frame(1, k, ac, frc, dc, w, rs, mf, sa, sb, bb, xa, db, ds);
      dyn_req = 0; stat_req = 0;
      model_served(exp_k);
      checks++; if (k !== exp_k) begin errors++; $display("FAIL rand_kind_%0d: got %0d expected %0d", i, k, exp_k); end
      checks++; if (sa !== (exp_k == 1)) begin errors++; $display("FAIL rand_sel_%0d: got %b expected %b", i, sa, exp_k == 1); end
      checks++; if (rs !== exp_n || w !== exp_w) begin errors++; $display("FAIL rand_word_%0d: got %h (%0d bits) expected %h (%0d bits)", i, w, rs, exp_w, exp_n); end
      checks++; if (dc !== ac + 2 * CD * exp_n + GAPC) begin errors++; $display("FAIL rand_done_time_%0d: got %0d expected %0d", i, dc, ac + 2 * CD * exp_n + GAPC); end
      @(negedge CLK);
    end
  endtask

  // test sequence and final report
  initial begin
    test_reset();
    test_single_dyn();
    test_single_stat();
    test_both_from_reset();
    test_no_starvation();
    test_reset_mid_frame();
    test_short_pulse();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
